// File: rtl/sc_speed_tick_gen_if.sv
// Control and status bundle for sc_speed_tick_gen. The distance output exists only when
// SC_COUNTER_DISTANCE_EN is defined.
interface sc_speed_tick_gen_if #(
  parameter int unsigned LEVEL_WIDTH = 3
`ifdef SC_COUNTER_DISTANCE_EN
  ,
  parameter int unsigned DIST_WIDTH  = 16
`endif
);
  logic                   SC_COUNTER_clear_InLow;
  logic                   SC_COUNTER_pause_InLow;
  logic                   SC_COUNTER_accel_InLow;
  logic                   SC_COUNTER_brake_InLow;
  logic                   SC_COUNTER_tick_OutLow;
  logic [LEVEL_WIDTH-1:0] SC_COUNTER_level_Out;
  logic                   SC_COUNTER_max_OutLow;
`ifdef SC_COUNTER_DISTANCE_EN
  logic [DIST_WIDTH-1:0]  SC_COUNTER_distance_Out;

  modport master (
    output SC_COUNTER_clear_InLow, SC_COUNTER_pause_InLow,
    output SC_COUNTER_accel_InLow, SC_COUNTER_brake_InLow,
    input  SC_COUNTER_tick_OutLow, SC_COUNTER_level_Out, SC_COUNTER_max_OutLow,
    input  SC_COUNTER_distance_Out
  );

  modport slave (
    input  SC_COUNTER_clear_InLow, SC_COUNTER_pause_InLow,
    input  SC_COUNTER_accel_InLow, SC_COUNTER_brake_InLow,
    output SC_COUNTER_tick_OutLow, SC_COUNTER_level_Out, SC_COUNTER_max_OutLow,
    output SC_COUNTER_distance_Out
  );
`else
  modport master (
    output SC_COUNTER_clear_InLow, SC_COUNTER_pause_InLow,
    output SC_COUNTER_accel_InLow, SC_COUNTER_brake_InLow,
    input  SC_COUNTER_tick_OutLow, SC_COUNTER_level_Out, SC_COUNTER_max_OutLow
  );

  modport slave (
    input  SC_COUNTER_clear_InLow, SC_COUNTER_pause_InLow,
    input  SC_COUNTER_accel_InLow, SC_COUNTER_brake_InLow,
    output SC_COUNTER_tick_OutLow, SC_COUNTER_level_Out, SC_COUNTER_max_OutLow
  );
`endif
endinterface

// File: rtl/sc_speed_tick_gen.sv
// Multi-level game-speed tick generator: active-low one-cycle tick whose period shrinks with a
// saturating speed level. SC_COUNTER_DISTANCE_EN adds a saturating count of issued ticks.
module sc_speed_tick_gen #(
  parameter int unsigned COUNTER_DATAWIDTH_BUS = 25,
  parameter int unsigned LEVEL_WIDTH           = 3,
  parameter int unsigned MAX_LEVEL             = 7,
  parameter int unsigned BASE_PERIOD           = 25000000,
  parameter int unsigned STEP_PERIOD           = 3000000
`ifdef SC_COUNTER_DISTANCE_EN
  ,
  parameter int unsigned DIST_WIDTH            = 16
`endif
) (
  input logic                SC_COUNTER_CLOCK_50,
  input logic                SC_COUNTER_RESET_InLow,
  sc_speed_tick_gen_if.slave sc_bus
);
  localparam int unsigned CW = COUNTER_DATAWIDTH_BUS;
  localparam int unsigned LW = LEVEL_WIDTH;

  localparam logic [CW-1:0] BasePeriod = CW'(BASE_PERIOD);
  localparam logic [CW-1:0] StepPeriod = CW'(STEP_PERIOD);
  localparam logic [LW-1:0] MaxLevel   = LW'(MAX_LEVEL);

  logic [CW-1:0] counter_q, counter_d;
  logic [CW-1:0] active_period_q, active_period_d;
  logic [CW-1:0] period_next;
  logic [LW-1:0] level_q, level_d;
  logic          tick_q, tick_d;
  logic          accel_req, brake_req;
  logic          wrap;

  assign accel_req = !sc_bus.SC_COUNTER_accel_InLow && sc_bus.SC_COUNTER_brake_InLow;
  assign brake_req = !sc_bus.SC_COUNTER_brake_InLow && sc_bus.SC_COUNTER_accel_InLow;

  always_comb begin
    level_d = level_q;
    if (accel_req && (level_q != MaxLevel)) begin
      level_d = level_q + LW'(1);
    end else if (brake_req && (level_q != '0)) begin
      level_d = level_q - LW'(1);
    end
  end

  // Period for the level that will be current after this edge; only latched on wrap or clear.
  assign period_next = BasePeriod - (CW'(level_d) * StepPeriod);
  assign wrap        = (counter_q == (active_period_q - CW'(1)));

  always_comb begin
    counter_d       = counter_q;
    active_period_d = active_period_q;
    tick_d          = 1'b1;
    if (!sc_bus.SC_COUNTER_clear_InLow) begin
      counter_d       = '0;
      active_period_d = period_next;
    end else if (!sc_bus.SC_COUNTER_pause_InLow) begin
      counter_d = counter_q;
    end else if (wrap) begin
      counter_d       = '0;
      active_period_d = period_next;
      tick_d          = 1'b0;
    end else begin
      counter_d = counter_q + CW'(1);
    end
  end

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      counter_q       <= '0;
      active_period_q <= BasePeriod;
      level_q         <= '0;
      tick_q          <= 1'b1;
    end else begin
      counter_q       <= counter_d;
      active_period_q <= active_period_d;
      level_q         <= level_d;
      tick_q          <= tick_d;
    end
  end

  assign sc_bus.SC_COUNTER_tick_OutLow = tick_q;
  assign sc_bus.SC_COUNTER_level_Out   = level_q;
  assign sc_bus.SC_COUNTER_max_OutLow  = (level_q != MaxLevel);

`ifdef SC_COUNTER_DISTANCE_EN
  logic [DIST_WIDTH-1:0] distance_q, distance_d;

  always_comb begin
    distance_d = distance_q;
    if (!sc_bus.SC_COUNTER_clear_InLow) begin
      distance_d = '0;
    end else if (!tick_d && (distance_q != '1)) begin
      distance_d = distance_q + DIST_WIDTH'(1);
    end
  end

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      distance_q <= '0;
    end else begin
      distance_q <= distance_d;
    end
  end

  assign sc_bus.SC_COUNTER_distance_Out = distance_q;
`endif
endmodule

// File: tb/tb_sc_speed_tick_gen.sv
// Bench for sc_speed_tick_gen: directed scenarios plus random control traffic, all checked
// against a countdown-style behavioural model of tick timing and speed level.
module tb_sc_speed_tick_gen;
  localparam int unsigned CW     = 8;
  localparam int unsigned LW     = 2;
  localparam int unsigned MaxLvl = 3;
  localparam int unsigned Base   = 10;
  localparam int unsigned Step   = 2;
  localparam int unsigned DW     = 16;
  localparam int          DistMax = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef SC_COUNTER_DISTANCE_EN
  sc_speed_tick_gen_if #(.LEVEL_WIDTH(LW), .DIST_WIDTH(DW)) bus ();
  sc_speed_tick_gen #(
    .COUNTER_DATAWIDTH_BUS(CW), .LEVEL_WIDTH(LW), .MAX_LEVEL(MaxLvl),
    .BASE_PERIOD(Base), .STEP_PERIOD(Step), .DIST_WIDTH(DW)
  ) dut (
    .SC_COUNTER_CLOCK_50(clk), .SC_COUNTER_RESET_InLow(rst_n), .sc_bus(bus.slave)
  );
`else
  sc_speed_tick_gen_if #(.LEVEL_WIDTH(LW)) bus ();
  sc_speed_tick_gen #(
    .COUNTER_DATAWIDTH_BUS(CW), .LEVEL_WIDTH(LW), .MAX_LEVEL(MaxLvl),
    .BASE_PERIOD(Base), .STEP_PERIOD(Step)
  ) dut (
    .SC_COUNTER_CLOCK_50(clk), .SC_COUNTER_RESET_InLow(rst_n), .sc_bus(bus.slave)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int tick_edges[$];

  // Model: edges remaining until the next tick, current level, issued-tick count.
  int   m_left;
  int   m_level;
  int   m_dist;
  logic m_tick;

  function automatic int period_of(input int lvl);
    return Base - lvl * Step;
  endfunction

  task automatic model_reset();
    m_left  = Base;
    m_level = 0;
    m_dist  = 0;
    m_tick  = 1'b1;
  endtask

  task automatic model_edge(input logic a, input logic b, input logic p, input logic c);
    if (!a && b && m_level < MaxLvl) m_level = m_level + 1;
    else if (!b && a && m_level > 0) m_level = m_level - 1;
    m_tick = 1'b1;
    if (!c) begin
      m_left = period_of(m_level);
      m_dist = 0;
    end else if (p) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_tick = 1'b0;
        m_left = period_of(m_level);
        if (m_dist < DistMax) m_dist = m_dist + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic check_outputs();
    check("tick", 32'(bus.SC_COUNTER_tick_OutLow), 32'(m_tick));
    check("level", 32'(bus.SC_COUNTER_level_Out), 32'(m_level));
    check("max", 32'(bus.SC_COUNTER_max_OutLow), 32'(m_level != MaxLvl));
`ifdef SC_COUNTER_DISTANCE_EN
    check("distance", 32'(bus.SC_COUNTER_distance_Out), 32'(m_dist));
`endif
  endtask

  task automatic step(input logic a, input logic b, input logic p, input logic c);
    bus.SC_COUNTER_accel_InLow = a;
    bus.SC_COUNTER_brake_InLow = b;
    bus.SC_COUNTER_pause_InLow = p;
    bus.SC_COUNTER_clear_InLow = c;
    @(posedge clk);
    model_edge(a, b, p, c);
    edge_n++;
    #1;
    check_outputs();
    if (bus.SC_COUNTER_tick_OutLow === 1'b0) tick_edges.push_back(edge_n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  // Asserts reset 3 time units after the last edge, checks the asynchronous effect, then
  // releases on the next falling edge so the following rising edge is edge 1.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_tick", 32'(bus.SC_COUNTER_tick_OutLow), 32'd1);
    check("async_rst_level", 32'(bus.SC_COUNTER_level_Out), 32'd0);
    check("async_rst_max", 32'(bus.SC_COUNTER_max_OutLow), 32'd1);
    bus.SC_COUNTER_accel_InLow = 1'b1;
    bus.SC_COUNTER_brake_InLow = 1'b1;
    bus.SC_COUNTER_pause_InLow = 1'b1;
    bus.SC_COUNTER_clear_InLow = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
    tick_edges.delete();
  endtask

  task automatic check_ticks(input string tag, input int idx, input int exp_edge);
    if (idx < tick_edges.size()) check(tag, 32'(tick_edges[idx]), 32'(exp_edge));
    else check(tag, 32'hFFFF_FFFF, 32'(exp_edge));
  endtask

  initial begin
    bus.SC_COUNTER_accel_InLow = 1'b1;
    bus.SC_COUNTER_brake_InLow = 1'b1;
    bus.SC_COUNTER_pause_InLow = 1'b1;
    bus.SC_COUNTER_clear_InLow = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Free running at level 0.
    idle(30);
    check("s1_count", 32'(tick_edges.size()), 32'd3);
    check_ticks("s1_t0", 0, 10);
    check_ticks("s1_t1", 1, 20);
    check_ticks("s1_t2", 2, 30);

    // Tick is low here; reset must raise it without an edge.
    do_reset();
    step(1, 1, 1, 1); step(0, 1, 1, 1); step(1, 1, 1, 1); step(0, 1, 1, 1);
    step(1, 1, 1, 1); step(0, 1, 1, 1); step(1, 1, 1, 1);
    check("s2_level", 32'(bus.SC_COUNTER_level_Out), 32'd3);
    check("s2_max", 32'(bus.SC_COUNTER_max_OutLow), 32'd0);
    idle(11);
    step(0, 1, 1, 1);
    check("s2_sat", 32'(bus.SC_COUNTER_level_Out), 32'd3);
    check_ticks("s2_t0", 0, 10);
    check_ticks("s2_t1", 1, 14);
    check_ticks("s2_t2", 2, 18);

    // Simultaneous accel/brake and brake at level 0.
    do_reset();
    step(1, 1, 1, 1); step(0, 0, 1, 1);
    check("s3_both", 32'(bus.SC_COUNTER_level_Out), 32'd0);
    step(0, 1, 1, 1); step(0, 0, 1, 1);
    check("s3_both_l1", 32'(bus.SC_COUNTER_level_Out), 32'd1);
    step(1, 0, 1, 1); step(1, 0, 1, 1);
    check("s3_floor", 32'(bus.SC_COUNTER_level_Out), 32'd0);

    // Pause edges 3..7 pushes the first tick to 15.
    do_reset();
    idle(2);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 1);
      check("s4_pause_tick", 32'(bus.SC_COUNTER_tick_OutLow), 32'd1);
    end
    idle(18);
    check_ticks("s4_t0", 0, 15);
    check_ticks("s4_t1", 1, 25);

    // Clear at edge 7 restarts the period: next tick at 17, none at 10.
    do_reset();
    idle(6);
    step(1, 1, 1, 0);
    idle(13);
    check("s5_count", 32'(tick_edges.size()), 32'd1);
    check_ticks("s5_t0", 0, 17);

    // Async reset mid-period at level 2, then normal 10-cycle spacing.
    do_reset();
    step(0, 1, 1, 1); step(0, 1, 1, 1);
    idle(3);
    check("s6_level", 32'(bus.SC_COUNTER_level_Out), 32'd2);
    do_reset();
    idle(20);
    check_ticks("s6_t0", 0, 10);
    check_ticks("s6_t1", 1, 20);

    // Random control traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(7) != 0), ($urandom_range(7) != 0),
           ($urandom_range(7) != 0), ($urandom_range(39) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
